// File: rtl/frame_serializer.sv
// Transmit-side serializer for the inter-layer 3D test link: sync header, payload MSB first, optional parity.
// Optional even-parity trailer is enabled with FRAME_SERIALIZER_PARITY_EN.
module frame_serializer #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5,
  parameter logic              IDLE_LVL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              data_out,
  output logic              tx_active,
  output logic              frame_done
);

  localparam int unsigned MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int unsigned CNT_W = $clog2(MAX_W);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  shreg;
  logic [SYNC_W-1:0]  sync_sh;
`ifdef FRAME_SERIALIZER_PARITY_EN
  logic               par_bit;
`endif

  logic take;
  assign take = in_valid && in_ready;

  // state names the field whose bit is on data_out during the current cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      sync_sh    <= '0;
      data_out   <= IDLE_LVL;
      tx_active  <= 1'b0;
      frame_done <= 1'b0;
      in_ready   <= 1'b1;
`ifdef FRAME_SERIALIZER_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (take) begin
        // accepted in IDLE or on the last bit: next cycle carries the sync MSB
        state     <= SYNC;
        cnt       <= '0;
        shreg     <= in_data;
        sync_sh   <= SYNC_WORD << 1;
        data_out  <= SYNC_WORD[SYNC_W-1];
        tx_active <= 1'b1;
        in_ready  <= 1'b0;
`ifdef FRAME_SERIALIZER_PARITY_EN
        par_bit   <= ^in_data;
`endif
      end else begin
        case (state)
          IDLE: begin
            data_out  <= IDLE_LVL;
            tx_active <= 1'b0;
            in_ready  <= 1'b1;
          end
          SYNC: begin
            if (cnt == CNT_W'(SYNC_W - 1)) begin
              state    <= DATA;
              cnt      <= '0;
              data_out <= shreg[DATA_W-1];
              shreg    <= shreg << 1;
            end else begin
              cnt      <= cnt + 1'b1;
              data_out <= sync_sh[SYNC_W-1];
              sync_sh  <= sync_sh << 1;
            end
          end
          DATA: begin
            if (cnt == CNT_W'(DATA_W - 1)) begin
`ifdef FRAME_SERIALIZER_PARITY_EN
              state      <= PAR;
              cnt        <= '0;
              data_out   <= par_bit;
              frame_done <= 1'b1;
              in_ready   <= 1'b1;
`else
              state      <= IDLE;
              cnt        <= '0;
              data_out   <= IDLE_LVL;
              tx_active  <= 1'b0;
              in_ready   <= 1'b1;
`endif
            end else begin
              cnt      <= cnt + 1'b1;
              data_out <= shreg[DATA_W-1];
              shreg    <= shreg << 1;
`ifndef FRAME_SERIALIZER_PARITY_EN
              if (cnt == CNT_W'(DATA_W - 2)) begin
                frame_done <= 1'b1;
                in_ready   <= 1'b1;
              end
`endif
            end
          end
          default: begin
            // parity cycle ended without a new word
            state     <= IDLE;
            cnt       <= '0;
            data_out  <= IDLE_LVL;
            tx_active <= 1'b0;
            in_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: directed scenarios plus random traffic against a bit-queue reference model.
module tb_frame_serializer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SYNC_W = 8;
  localparam logic [7:0]  SYNC_WORD = 8'hA5;
`ifdef FRAME_SERIALIZER_PARITY_EN
  localparam int unsigned L = 41;
`else
  localparam int unsigned L = 40;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        data_out;
  logic        tx_active;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  bit q[$];
  bit last_tr;
  int fd_cnt;
  int act_cnt;
  logic [63:0] cap;
  logic [63:0] exp_cap;
  int waited;

  frame_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .tx_active  (tx_active),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference frame: sync word MSB first, payload MSB first, optional even parity.
  task automatic push_frame(input logic [31:0] w);
    for (int i = SYNC_W - 1; i >= 0; i--) q.push_back(bit'((SYNC_WORD >> i) & 8'd1));
    for (int i = DATA_W - 1; i >= 0; i--) q.push_back(w[i]);
`ifdef FRAME_SERIALIZER_PARITY_EN
    q.push_back(bit'($countones(w) % 2));
`endif
  endtask

  // One clock: predict transfer, advance model, then compare all outputs 1ns after the edge.
  task automatic step();
    bit tr;
    bit e_do;
    tr = (in_valid === 1'b1) && (q.size() <= 1) && (rst === 1'b0);
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (q.size() > 0) void'(q.pop_front());
      if (tr) push_frame(in_data);
    end
    last_tr = tr;
    #1;
    e_do = (q.size() > 0) ? q[0] : 1'b0;
    chk("data_out",   64'(data_out),   64'(e_do));
    chk("tx_active",  64'(tx_active),  64'(q.size() > 0));
    chk("frame_done", 64'(frame_done), 64'(q.size() == 1));
    chk("in_ready",   64'(in_ready),   64'(q.size() <= 1));
    if (tx_active === 1'b1) begin
      act_cnt++;
      cap = {cap[62:0], data_out};
    end
    if (frame_done === 1'b1) fd_cnt++;
  endtask

  initial begin
    // Power-on reset with in_valid held high: ignored until release
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = $urandom;
    repeat (3) step();
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("first_edge_transfer", 64'(last_tr), 64'(1));
    in_valid = 1'b0;
    in_data = 'x;
    repeat (L + 3) step();

    // Reset mid-cycle while idle, then 20 idle cycles with X on in_data
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("idle_rst_do", 64'(data_out), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (20) step();

    // Single DEADBEEF frame
    fd_cnt = 0; act_cnt = 0; cap = '0;
    in_valid = 1'b1;
    in_data = 32'hDEADBEEF;
    step();
    in_valid = 1'b0;
    in_data = 'x;
    repeat (L + 4) step();
    exp_cap = {24'd0, 8'hA5, 32'hDEADBEEF};
`ifdef FRAME_SERIALIZER_PARITY_EN
    exp_cap = {exp_cap[62:0], ^exp_cap[31:0]};
`endif
    chk("single_bits", cap & ((64'd1 << L) - 64'd1), exp_cap);
    chk("single_active_len", 64'(act_cnt), 64'(L));
    chk("single_done_cnt", 64'(fd_cnt), 64'(1));

    // Back-to-back with in_valid held high
    fd_cnt = 0; act_cnt = 0;
    in_valid = 1'b1;
    in_data = 32'h00000001;
    step();
    in_data = 32'h80000000;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!last_tr && waited < L + 5);
    chk("b2b_second_accept_at", 64'(waited), 64'(L));
    in_valid = 1'b0;
    in_data = 'x;
    repeat (L + 3) step();
    chk("b2b_active_len", 64'(act_cnt), 64'(2 * L));
    chk("b2b_done_cnt", 64'(fd_cnt), 64'(2));

    // Stall: offer a word while a frame is at bit ~10 of its payload
    in_valid = 1'b1;
    in_data = $urandom;
    step();
    in_data = 'x;
    in_valid = 1'b0;
    repeat (SYNC_W + 10) step();
    in_valid = 1'b1;
    in_data = 32'h12345678;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!last_tr && waited < L + 5);
    chk("stall_accept_at", 64'(waited), 64'(L - SYNC_W - 10));
    in_valid = 1'b0;
    in_data = 'x;
    repeat (L + 3) step();

    // Reset at payload bit 5 of FFFFFFFF
    fd_cnt = 0;
    in_valid = 1'b1;
    in_data = 32'hFFFFFFFF;
    step();
    in_valid = 1'b0;
    in_data = 'x;
    repeat (SYNC_W + 5) step();
    chk("pre_rst_do", 64'(data_out), 64'(1));
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    chk("rst_async_do", 64'(data_out), 64'(0));
    chk("rst_async_act", 64'(tx_active), 64'(0));
    chk("rst_async_done", 64'(frame_done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    chk("rst_no_done", 64'(fd_cnt), 64'(0));
    fd_cnt = 0; act_cnt = 0; cap = '0;
    in_valid = 1'b1;
    in_data = 32'h0000000F;
    step();
    in_valid = 1'b0;
    in_data = 'x;
    repeat (L + 3) step();
    exp_cap = {24'd0, 8'hA5, 32'h0000000F};
`ifdef FRAME_SERIALIZER_PARITY_EN
    exp_cap = {exp_cap[62:0], 1'b0};
`endif
    chk("post_rst_bits", cap & ((64'd1 << L) - 64'd1), exp_cap);
    chk("post_rst_done", 64'(fd_cnt), 64'(1));

`ifdef FRAME_SERIALIZER_PARITY_EN
    // Parity trailer: 7 has odd weight, 3 has even weight
    fd_cnt = 0; act_cnt = 0; cap = '0;
    in_valid = 1'b1;
    in_data = 32'h00000007;
    step();
    in_valid = 1'b0;
    in_data = 'x;
    repeat (L + 2) step();
    chk("par7_bit", 64'(cap[0]), 64'(1));
    chk("par7_len", 64'(act_cnt), 64'(41));
    in_valid = 1'b1;
    in_data = 32'h00000003;
    step();
    in_valid = 1'b0;
    in_data = 'x;
    repeat (L + 2) step();
    chk("par3_bit", 64'(cap[0]), 64'(0));
    chk("par_done_cnt", 64'(fd_cnt), 64'(2));
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      if (in_valid) in_data = $urandom;
      else in_data = 'x;
      step();
    end
    in_valid = 1'b0;
    in_data = 'x;
    repeat (L + 3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
